mont_mul_seq: RTL and testbench

- Iterative Montgomery modular multiplier: res = a·b·R⁻¹ mod n, with R = 2^LEN.
- Word-serial REDC at radix 2^W. Digit quotient is derived from the low W bits of n_prime, where n_prime = −n⁻¹ mod R.
- Core primitive for the RSA/ECC modular-exponentiation datapath; operands are latched on a start/done handshake.

---
 rtl/mont_mul_pkg.sv | 19 +
 rtl/mont_mul_seq_if.sv | 37 +++
 rtl/mont_mul_seq_step.sv | 27 ++
 rtl/mont_mul_seq.sv | 129 ++++++++++++
 tb/tb_mont_mul_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mont_mul_pkg.sv
// Shared constants and types for the Montgomery multiplier.
// Default operand width, digit width and FSM encoding.
package mont_mul_pkg;

  localparam int LEN_D  = 256;
  localparam int W_D    = 8;
  localparam int ITER_D = LEN_D / W_D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } state_t;

  function automatic int cnt_w(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/mont_mul_seq_if.sv
// Request/response bundle of the Montgomery multiplier.
// MONT_MUL_ERR_CHECK_EN adds the err flag.
interface mont_mul_seq_if
  import mont_mul_pkg::*;
#(
  parameter int LEN = LEN_D
);

  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic [LEN-1:0] n;
  logic [LEN-1:0] n_prime;
  logic [LEN-1:0] res;
  logic           busy;
  logic           done;
`ifdef MONT_MUL_ERR_CHECK_EN
  logic           err;
`endif

  modport master (
    output start, a, b, n, n_prime,
`ifdef MONT_MUL_ERR_CHECK_EN
    input  err,
`endif
    input  res, busy, done
  );

  modport slave (
    input  start, a, b, n, n_prime,
`ifdef MONT_MUL_ERR_CHECK_EN
    output err,
`endif
    output res, busy, done
  );

endinterface

// File: rtl/mont_mul_seq_step.sv
// One radix-2^W REDC iteration: S' = (S + ai*b + q*n) >> W.
// q is chosen so the low digit of the sum cancels.
module mont_digit_step #(
  parameter int LEN = 256,
  parameter int W   = 8
) (
  input  logic [LEN+W:0] s,
  input  logic [W-1:0]   ai,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] n,
  input  logic [W-1:0]   np0,
  output logic [LEN+W:0] s_nxt
);

  localparam int XW = LEN + W + 2;

  logic [XW-1:0] t;
  logic [XW-1:0] u;
  logic [W-1:0]  q;

  assign t = XW'(s) + XW'(ai) * XW'(b);
  assign q = t[W-1:0] * np0;
  assign u = t + XW'(q) * XW'(n);

  assign s_nxt = (LEN+W+1)'(u >> W);

endmodule

// File: rtl/mont_mul_seq.sv
// Sequential Montgomery multiplier, res = a*b*2^-LEN mod n.
// MONT_MUL_ERR_CHECK_EN flags out-of-contract operands on err.
module mont_mul_seq
  import mont_mul_pkg::*;
#(
  parameter int LEN = LEN_D,
  parameter int W   = W_D
) (
  input logic          clk,
  input logic          rst_n,
  mont_mul_seq_if.slave bus
);

  localparam int ITER = LEN / W;
  localparam int CW   = cnt_w(ITER);
  localparam int SW   = LEN + W + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t         state;
  state_t         state_n;
  logic [LEN-1:0] a_q;
  logic [LEN-1:0] b_q;
  logic [LEN-1:0] n_q;
  logic [LEN-1:0] res_q;
  logic [W-1:0]   np_q;
  logic [SW-1:0]  s_q;
  logic [SW-1:0]  s_nxt;
  logic [SW-1:0]  s_sub;
  logic [CW-1:0]  i_q;
  logic           busy_q;
  logic           done_q;
  logic           ge;

`ifdef MONT_MUL_ERR_CHECK_EN
  logic err_p;
  logic err_q;
  logic err_in;

  assign err_in = ~bus.n[0]
                | (bus.a >= bus.n)
                | (bus.b >= bus.n);
  assign bus.err = err_q;
`endif

  mont_digit_step #(
    .LEN (LEN),
    .W   (W)
  ) u_step (
    .s     (s_q),
    .ai    (a_q[W-1:0]),
    .b     (b_q),
    .n     (n_q),
    .np0   (np_q),
    .s_nxt (s_nxt)
  );

  assign ge    = s_q >= SW'(n_q);
  assign s_sub = s_q - SW'(n_q);

  assign bus.res  = res_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Next-state: one start, ITER digit steps, one final reduction.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (i_q == LAST) state_n = FINAL;
      FINAL:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, digit iteration and result/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      np_q   <= '0;
      s_q    <= '0;
      i_q    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MONT_MUL_ERR_CHECK_EN
      err_p  <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            n_q    <= bus.n;
            np_q   <= bus.n_prime[W-1:0];
            s_q    <= '0;
            i_q    <= '0;
            busy_q <= 1'b1;
`ifdef MONT_MUL_ERR_CHECK_EN
            err_p  <= err_in;
            err_q  <= 1'b0;
`endif
          end
        end
        RUN: begin
          s_q <= s_nxt;
          a_q <= a_q >> W;
          i_q <= i_q + CW'(1);
        end
        FINAL: begin
          res_q  <= ge ? LEN'(s_sub) : LEN'(s_q);
          done_q <= 1'b1;
          busy_q <= 1'b0;
`ifdef MONT_MUL_ERR_CHECK_EN
          err_q  <= err_p;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_seq.sv
// Scoreboard bench for mont_mul_seq at LEN=256, W=8.
// Builds with or without MONT_MUL_ERR_CHECK_EN.
module tb_mont_mul_seq;
  import mont_mul_pkg::*;

  localparam int LEN = 256;
  localparam int LAT = 33;

  typedef logic [LEN-1:0] word_t;
  typedef struct {
    word_t res;
    bit    cres;
    bit    err;
  } exp_t;

  localparam word_t A1 =
    256'hA1B2C3D4E5F67890123456789012345678901234567890123456789012345678;
  localparam word_t B1 =
    256'hFEDCBA9876543210FEDCBA9876543210FEDCBA9876543210FEDCBA9876543210;
  localparam word_t N1 =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam word_t NP =
    256'hc9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531;
  localparam word_t E1 =
    256'h7aadc2413b5165dc519412c9bc08ed5664e6cb765385e169d15d7d144a67646a;
  localparam word_t NE =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E;
  localparam word_t RM = 256'h1000003D1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dones = 0;
  int   cyc = 0;
  int   st_cyc = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mont_mul_seq_if #(.LEN(LEN)) bus();

  mont_mul_seq #(
    .LEN (LEN),
    .W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t rnd();
    word_t r;
    for (int i = 0; i < LEN / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // a*b mod n by binary Horner, then LEN halvings mod n.
  function automatic word_t mont_ref(input word_t x, input word_t y,
                                     input word_t m);
    logic [LEN+1:0] r;
    r = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {2'b00, m}) r = r - {2'b00, m};
      if (x[i]) r = r + {2'b00, y};
      if (r >= {2'b00, m}) r = r - {2'b00, m};
    end
    for (int i = 0; i < LEN; i++) begin
      if (r[0]) r = r + {2'b00, m};
      r = r >> 1;
    end
    return r[LEN-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pops one expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      dones++;
      chk("latency", word_t'(cyc - st_cyc), word_t'(LAT));
      chk("busy_at_done", word_t'(bus.busy), '0);
      chk("sb_depth", word_t'(sbq.size()), word_t'(1));
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        if (e.cres) chk("res", bus.res, e.res);
`ifdef MONT_MUL_ERR_CHECK_EN
        chk("err", word_t'(bus.err), word_t'(e.err));
`endif
      end
    end
  end

  task automatic run(input word_t ta, input word_t tb_, input word_t tn,
                     input word_t er, input bit cres, input bit eerr,
                     input bit b2b, input int pulse);
    exp_t e;
    int   d0;
    e.res  = er;
    e.cres = cres;
    e.err  = eerr;
    sbq.push_back(e);
    if (!b2b) @(negedge clk);
    bus.a       = ta;
    bus.b       = tb_;
    bus.n       = tn;
    bus.n_prime = NP;
    bus.start   = 1'b1;
    d0 = dones;
    @(posedge clk);
    #1;
    st_cyc = cyc;
    bus.start = 1'b0;
    chk("busy_after_start", word_t'(bus.busy), word_t'(1));
    bus.a       = rnd();
    bus.b       = rnd();
    bus.n       = rnd();
    bus.n_prime = rnd();
    for (int k = 1; k <= LAT + 10 && dones == d0; k++) begin
      @(negedge clk);
      bus.start = (k == pulse);
    end
    bus.start = 1'b0;
    chk("done_seen", word_t'(dones - d0), word_t'(1));
  endtask

  initial begin
    word_t x;
    word_t y;
    int    d0;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.n       = '0;
    bus.n_prime = '0;
    repeat (3) @(negedge clk);
    chk("rst_res", bus.res, '0);
    chk("rst_busy", word_t'(bus.busy), '0);
    chk("rst_done", word_t'(bus.done), '0);
    rst_n = 1'b1;

    run(A1, B1, N1, E1, 1, 0, 0, 0);
    run(B1, A1, N1, E1, 1, 0, 1, 0);
    run(RM, B1, N1, B1, 1, 0, 0, 0);
    run('0, B1, N1, '0, 1, 0, 0, 0);

    for (int v = 0; v < 3; v++) begin
      x = rnd();
      y = rnd();
      if (x >= N1) x = x - N1;
      if (y >= N1) y = y - N1;
      run(x, y, N1, mont_ref(x, y, N1), 1, 0, 0, 0);
    end

    run(A1, B1, N1, E1, 1, 0, 0, 5);
    d0 = dones;
    repeat (40) @(negedge clk);
    chk("single_done", word_t'(dones), word_t'(d0));

    @(negedge clk);
    bus.a       = A1;
    bus.b       = B1;
    bus.n       = N1;
    bus.n_prime = NP;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    d0 = dones;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_res", bus.res, '0);
    chk("abort_busy", word_t'(bus.busy), '0);
    chk("abort_done", word_t'(bus.done), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", word_t'(dones), word_t'(d0));

    run(A1, B1, N1, E1, 1, 0, 0, 0);
    run(A1, B1, NE, '0, 0, 1, 0, 0);
    run(N1, B1, N1, '0, 0, 1, 0, 0);
    run(A1, B1, N1, E1, 1, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("sb_left", word_t'(sbq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
